// File: rtl/s_out_collector.sv
// Collects PE result words into a small FIFO and streams them downstream with last/done framing.
// Optional stall counter enabled by defining S_OUT_STALL_CNT_EN.
module s_out_collector #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mage_done_i,
  input  logic              start_i,
  input  logic [15:0]       cfg_len_i,
  input  logic              pe_valid_i,
  input  logic [N_BITS-1:0] pe_res_i,
  output logic              pea_ready_o,
  output logic              out_valid_o,
  output logic [N_BITS-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              done_o,
  output logic [15:0]       stall_cnt_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [N_BITS-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [15:0]        len, in_cnt, out_cnt;
  logic               full, empty, push, pop, start_ok, last_pop, done_nxt;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign pea_ready_o = (state == RUN) && !full;
  assign out_valid_o = !empty;
  // Head is masked while empty so the stream data reads 0 out of reset.
  assign out_data_o  = empty ? '0 : mem[rd_ptr];
  assign out_last_o  = out_valid_o && (out_cnt == len - 16'd1);

  // Abort wins over every other event in the same cycle.
  assign push     = pe_valid_i && pea_ready_o && !mage_done_i;
  assign pop      = out_valid_o && out_ready_i && !mage_done_i;
  assign start_ok = (state == IDLE) && start_i && !mage_done_i;
  assign last_pop = pop && (state == DRAIN) && (out_cnt == len - 16'd1);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start_ok) begin
        if (cfg_len_i != 16'd0) state_nxt = RUN;
        else                    done_nxt  = 1'b1;
      end
      RUN:   if (push && (in_cnt == len - 16'd1)) state_nxt = DRAIN;
      DRAIN: if (last_pop) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (mage_done_i) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      done_o <= 1'b0;
    end else begin
      state <= state_nxt;
      done_o <= done_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pe_res_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mage_done_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (mage_done_i) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (start_ok && cfg_len_i != 16'd0) begin
      len     <= cfg_len_i;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) in_cnt  <= in_cnt + 16'd1;
      if (pop)  out_cnt <= out_cnt + 16'd1;
    end
  end

`ifdef S_OUT_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      stall_cnt <= '0;
    else if (mage_done_i || start_ok)  stall_cnt <= '0;
    else if (out_valid_o && !out_ready_i && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_s_out_collector.sv
// Directed + random bench for s_out_collector against a queue-based reference model.
module tb_s_out_collector;
  localparam int NB = 32;
  localparam int D  = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mage_done, start, pe_valid, out_ready;
  logic [15:0]   cfg_len;
  logic [NB-1:0] pe_res;
  logic          pea_ready, out_valid, out_last, done;
  logic [NB-1:0] out_data;
  logic [15:0]   stall_cnt;

  int errors = 0;
  int checks = 0;
  int dut_acc = 0;

  // Reference model: what the block should hold, in plain terms.
  int            mmode;
  logic [NB-1:0] q[$];
  logic [15:0]   mlen, min_n, mout_n, mstall;
  logic          mdone;

  s_out_collector #(.N_BITS(NB), .DEPTH(D)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mage_done_i(mage_done), .start_i(start),
    .cfg_len_i(cfg_len), .pe_valid_i(pe_valid), .pe_res_i(pe_res),
    .pea_ready_o(pea_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_last_o(out_last), .out_ready_i(out_ready), .done_o(done),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mmode = M_IDLE; min_n = 0; mout_n = 0; mdone = 0; mstall = 0;
  endtask

  task automatic check_outs();
    logic          v;
    logic [15:0]   lm1;
    logic [15:0]   es;
    v   = (q.size() > 0);
    lm1 = mlen - 16'd1;
`ifdef S_OUT_STALL_CNT_EN
    es = mstall;
`else
    es = 16'd0;
`endif
    chk("pea_ready", 32'(pea_ready), 32'((mmode == M_RUN) && (q.size() < D)));
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_data",  out_data, v ? q[0] : '0);
    chk("out_last",  32'(out_last), 32'(v && (mout_n == lm1)));
    chk("done",      32'(done), 32'(mdone));
    chk("stall_cnt", 32'(stall_cnt), 32'(es));
  endtask

  // One cycle: check current outputs, drive inputs, advance the model, move to next negedge.
  task automatic step(input logic st, input logic [15:0] ln, input logic pv,
                      input logic [NB-1:0] d, input logic ordy, input logic mg);
    int   om;
    logic v, rdy;
    check_outs();
    start = st; cfg_len = ln; pe_valid = pv; pe_res = d; out_ready = ordy; mage_done = mg;
    if (pea_ready && pv && !mg) dut_acc++;
    om  = mmode;
    v   = (q.size() > 0);
    rdy = (om == M_RUN) && (q.size() < D);
    if (mg) begin
      model_clear();
    end else begin
      mdone = 0;
      if (om == M_IDLE && st) mstall = 0;
      else if (v && !ordy && mstall != 16'hFFFF) mstall++;
      if (v && ordy) begin
        void'(q.pop_front());
        mout_n++;
        if (om == M_DRAIN && mout_n == mlen) begin mdone = 1; mmode = M_IDLE; end
      end
      if (rdy && pv) begin
        q.push_back(d);
        min_n++;
        if (min_n == mlen) mmode = M_DRAIN;
      end
      if (om == M_IDLE && st) begin
        if (ln != 16'd0) begin mlen = ln; min_n = 0; mout_n = 0; mmode = M_RUN; end
        else mdone = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ordy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    mlen = 0;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    start = 0; cfg_len = 0; pe_valid = 0; pe_res = 0; out_ready = 0; mage_done = 0;
    mlen = 0;
    do_reset();

    // Three back-to-back words with a ready sink.
    step(1, 3, 0, 0, 1, 0);
    step(0, 0, 1, 32'hA, 1, 0);
    step(0, 0, 1, 32'hB, 1, 0);
    step(0, 0, 1, 32'hC, 1, 0);
    idle(4, 1);

    // Backpressure: only DEPTH words fit, then drain everything in order.
    step(1, 6, 0, 0, 0, 0);
    base = dut_acc;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h100 + i, 0, 0);
    chk("acc_until_full", 32'(dut_acc - base), 32'(D));
    chk("ready_when_full", 32'(pea_ready), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h200 + i, 1, 0);
    idle(3, 1);

    // Simultaneous push/pop with two words resident, across pointer wrap.
    step(1, 10, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 0, 0);
    step(0, 0, 1, 32'h301, 0, 0);
    for (int i = 2; i < 10; i++) step(0, 0, 1, 32'h300 + i, 1, 0);
    idle(4, 1);

    // Zero-length collection.
    step(1, 0, 1, 32'hDEAD, 1, 0);
    idle(3, 1);

    // Abort after two of five words, then a normal single-word run.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 32'h400, 0, 0);
    step(0, 0, 1, 32'h401, 0, 0);
    step(1, 7, 1, 32'h402, 1, 1);
    idle(2, 1);
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 32'h500, 1, 0);
    idle(3, 1);

    // Reset mid-collection discards data.
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 1, 32'h600, 0, 0);
    step(0, 0, 1, 32'h601, 0, 0);
    do_reset();
    idle(2, 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 5) == 0, 16'($urandom % 9), ($urandom % 3) != 0, $urandom,
           ($urandom % 3) != 0, ($urandom % 60) == 0);
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/s_out_collector.md
S_OUT_COLLECTOR -- requirements
Module: s_out_collector

Interface
REQ-001 Parameter N_BITS, default 32, width of one PE result word.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of 2 and at least 2.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 mage_done_i  in  1  global abort/finish; flushes the block.
REQ-006 start_i  in  1  one-cycle pulse; arms a new collection.
REQ-007 cfg_len_i  in  16  number of results to collect; sampled on start_i.
REQ-008 pe_valid_i  in  1  PE output valid.
REQ-009 pe_res_i  in  N_BITS  PE result word.
REQ-010 pea_ready_o  out  1  backpressure to the PE array.
REQ-011 out_valid_o  out  1  downstream stream valid.
REQ-012 out_data_o  out  N_BITS  downstream stream data.
REQ-013 out_last_o  out  1  marks the final word of the collection.
REQ-014 out_ready_i  in  1  downstream stream ready.
REQ-015 done_o  out  1  one-cycle pulse when a collection completes.
REQ-016 stall_cnt_o  out  16  downstream stall cycle count (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE, start_i=1 and cfg_len_i!=0: latch len, clear in_cnt and out_cnt, go to RUN next cycle.
REQ-019 IDLE, start_i=1 and cfg_len_i==0: done_o pulses the next cycle; state stays IDLE.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 pea_ready_o SHALL be (state==RUN) and FIFO not full; it is combinational from registered state only.
REQ-022 A word is accepted when pe_valid_i and pea_ready_o are both high.
- An accepted word is written into the FIFO.
- in_cnt increments by 1.
REQ-023 When an accept brings in_cnt to len, the next state SHALL be DRAIN; pea_ready_o is low from that cycle on.
REQ-024 out_valid_o SHALL be high whenever the FIFO is not empty; out_data_o is the FIFO head.
REQ-025 A word is popped when out_valid_o and out_ready_i are both high; out_cnt increments by 1.
REQ-026 out_data_o and out_valid_o SHALL stay stable while out_valid_o is high and out_ready_i is low.
REQ-027 out_last_o SHALL equal out_valid_o and (out_cnt == len-1).
REQ-028 Push and pop in the same cycle SHALL leave the FIFO occupancy unchanged, with data order preserved.
REQ-029 A push is impossible when the FIFO is full; a pop is impossible when it is empty.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 Write-to-read latency: a word accepted in cycle t SHALL be visible on out_data_o in cycle t+1 if the FIFO was empty.
REQ-032 DRAIN, when the pop of the last word occurs (out_cnt reaches len): done_o pulses the next cycle and state returns to IDLE.
REQ-033 mage_done_i=1 in any state: next cycle, state IDLE, FIFO emptied, counters cleared, no done_o pulse.
REQ-034 mage_done_i has priority over start_i, accept and pop in the same cycle.

Reset
REQ-035 On rst_n_i low, the following SHALL take their reset values:
- state: IDLE
- FIFO: empty, pointers 0, counters 0, len 0
- done_o: 0
- stall_cnt_o: 0
- Consequently pea_ready_o=0, out_valid_o=0, out_last_o=0, out_data_o=0.
REQ-036 Reset asserted mid-collection SHALL discard all stored data without any done_o pulse.

Configuration
REQ-037 Macro S_OUT_STALL_CNT_EN enables the stall counter.
- Defined: stall_cnt_o increments each cycle with out_valid_o=1 and out_ready_i=0.
- It saturates at 0xFFFF.
- It clears on an accepted start_i and on mage_done_i.
REQ-038 Macro S_OUT_STALL_CNT_EN not defined: stall_cnt_o SHALL be constant 0 and no counter register exists; the port remains present.

Verification
REQ-039 Start with cfg_len=3 and out_ready_i=1; PE supplies 0xA, 0xB, 0xC back-to-back.
- Outputs 0xA, 0xB, 0xC, each one cycle after its accept.
- out_last_o high with 0xC.
- done_o pulses one cycle after that final pop.
REQ-040 DEPTH=4, cfg_len=6, out_ready_i=0; PE streams continuously.
- Exactly 4 words accepted, then pea_ready_o=0.
- Releasing out_ready_i drains all 6 words in order.
- With S_OUT_STALL_CNT_EN defined, stall_cnt_o equals the number of stalled cycles.
REQ-041 FIFO holding 2 words, push and pop in the same cycle: occupancy stays 2 and order is preserved across pointer wrap after 10 words.
REQ-042 Start with cfg_len=0 -> done_o pulses the next cycle, no outputs, pea_ready_o stays 0.
REQ-043 mage_done_i pulse after 2 of 5 words -> next cycle IDLE, out_valid_o=0, no done_o; a new start with cfg_len=1 completes normally.
